// File: rtl/apmu_ibex_dummy_instr_burst.sv
// apmu_ibex_dummy_instr_burst
// Inserts pseudo-random dummy ALU/MUL/DIV instructions into the IF/ID stream.
// A 32-bit Galois LFSR provides the inter-dummy count threshold, the operand
// fields, the instruction type and the optional burst length. All outputs are
// driven straight from flops.
// Optional feature: define APMU_DUMMY_INSTR_STATS_EN to count accepted dummies
// on dummy_instr_cnt_o; without it the output is tied to zero and has no flops.
module apmu_ibex_dummy_instr_burst #(
  parameter int unsigned CntW     = 5,
  parameter int unsigned MaskW    = 3,
  parameter int unsigned MaxBurst = 4,
  parameter logic [31:0] LfsrSeed = 32'hDEAD_BEEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dummy_instr_en_i,
  input  logic [MaskW-1:0] dummy_instr_mask_i,
  input  logic             dummy_burst_en_i,
  input  logic             dummy_instr_seed_en_i,
  input  logic [31:0]      dummy_instr_seed_i,
  input  logic             fetch_valid_i,
  input  logic             id_in_ready_i,
  output logic             insert_dummy_instr_o,
  output logic [31:0]      dummy_instr_data_o,
  output logic             dummy_burst_active_o,
  output logic [31:0]      dummy_instr_cnt_o
);

  localparam int unsigned BurstFW  = $clog2(MaxBurst);
  localparam int unsigned RemW     = (BurstFW > 0) ? BurstFW : 1;
  localparam int unsigned OpAPos   = CntW;
  localparam int unsigned OpBPos   = CntW + 5;
  localparam int unsigned TypePos  = CntW + 10;
  localparam int unsigned BurstPos = CntW + 12;
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  typedef enum logic [0:0] {
    ST_COUNT  = 1'b0,
    ST_INSERT = 1'b1
  } state_e;

  // One Galois LFSR step; a zero input yields the recovery seed.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] v;
    v = s[0] ? ({1'b0, s[31:1]} ^ LfsrPoly) : {1'b0, s[31:1]};
    return (v == 32'h0) ? LfsrSeed : v;
  endfunction

  // R-type encoding of the dummy selected by the LFSR fields, rd = x0.
  function automatic logic [31:0] encode(input logic [31:0] s);
    logic [6:0] f7;
    logic [2:0] f3;
    case (s[TypePos +: 2])
      2'd0:    begin f7 = 7'b000_0000; f3 = 3'b000; end  // ADD
      2'd1:    begin f7 = 7'b000_0001; f3 = 3'b000; end  // MUL
      2'd2:    begin f7 = 7'b000_0001; f3 = 3'b100; end  // DIV
      2'd3:    begin f7 = 7'b000_0000; f3 = 3'b111; end  // AND
      default: begin f7 = 7'b000_0000; f3 = 3'b000; end
    endcase
    return {f7, s[OpBPos +: 5], s[OpAPos +: 5], f3, 5'h00, 7'h33};
  endfunction

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [RemW-1:0] r_rem;
  logic [31:0]     r_seed;
  logic [31:0]     r_lfsr;
  logic            r_insert;
  logic [31:0]     r_data;
  logic            r_active;

  state_e          w_state_nxt;
  logic [CntW-1:0] w_cnt_nxt;
  logic [RemW-1:0] w_rem_nxt;
  logic [31:0]     w_seed_nxt;
  logic [31:0]     w_lfsr_nxt;
  logic            w_insert_nxt;
  logic [31:0]     w_data_nxt;
  logic            w_active_nxt;
  logic            w_accept;
  logic            w_hold;
  logic [CntW-1:0] w_mask_full;
  logic [CntW-1:0] w_thresh;
  logic [RemW-1:0] w_burst;

  // Mask covers the upper count bits; the lower CntW-MaskW bits always pass.
  assign w_mask_full = (CntW'(dummy_instr_mask_i) << (CntW - MaskW))
                     | CntW'((32'd1 << (CntW - MaskW)) - 32'd1);
  assign w_thresh    = r_lfsr[CntW-1:0] & w_mask_full;
  assign w_burst     = (BurstFW == 0) ? '0 : r_lfsr[BurstPos +: RemW];

  // Next-state, counter, burst, LFSR/seed and registered-output images.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_seed_nxt   = r_seed;
    w_lfsr_nxt   = r_lfsr;
    w_insert_nxt = 1'b0;
    w_data_nxt   = 32'h0;
    w_active_nxt = 1'b0;
    w_accept     = 1'b0;
    w_hold       = 1'b0;

    case (r_state)
      ST_COUNT: begin
        if (dummy_instr_en_i && (r_cnt == w_thresh)) begin
          w_state_nxt = ST_INSERT;
          w_cnt_nxt   = '0;
          w_rem_nxt   = dummy_burst_en_i ? w_burst : '0;
        end else if (fetch_valid_i && id_in_ready_i && dummy_instr_en_i) begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_INSERT: begin
        if (id_in_ready_i) begin
          w_accept = 1'b1;
          if (r_rem == '0) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_rem_nxt = r_rem - RemW'(1);
          end
        end else if (!dummy_instr_en_i) begin
          // Insertion withdrawn before acceptance: abandon the dummy.
          w_state_nxt = ST_COUNT;
          w_rem_nxt   = '0;
        end else begin
          w_hold = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_COUNT;
        w_cnt_nxt   = '0;
        w_rem_nxt   = '0;
      end
    endcase

    // Reseeding overrides an advance in the same cycle; zero is never loaded.
    if (dummy_instr_seed_en_i) begin
      w_seed_nxt = r_seed ^ dummy_instr_seed_i;
      w_lfsr_nxt = (w_seed_nxt == 32'h0) ? LfsrSeed : w_seed_nxt;
    end else if (w_accept || (r_lfsr == 32'h0)) begin
      w_lfsr_nxt = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt = r_lfsr;
    end

    // A stalled dummy keeps its encoding even if the LFSR is reseeded.
    if (w_state_nxt == ST_INSERT) begin
      w_insert_nxt = 1'b1;
      w_data_nxt   = w_hold ? r_data : encode(w_lfsr_nxt);
      w_active_nxt = (w_rem_nxt != '0);
    end else begin
      w_insert_nxt = 1'b0;
      w_data_nxt   = 32'h0;
      w_active_nxt = 1'b0;
    end
  end

  // State, counters, LFSR and output flops with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_COUNT;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_seed   <= 32'h0;
      r_lfsr   <= LfsrSeed;
      r_insert <= 1'b0;
      r_data   <= 32'h0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_seed   <= w_seed_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_insert <= w_insert_nxt;
      r_data   <= w_data_nxt;
      r_active <= w_active_nxt;
    end
  end

  assign insert_dummy_instr_o = r_insert;
  assign dummy_instr_data_o   = r_data;
  assign dummy_burst_active_o = r_active;

`ifdef APMU_DUMMY_INSTR_STATS_EN
  logic [31:0] r_dcnt;

  // Saturating count of accepted dummies.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_dcnt <= 32'h0;
    end else if (w_accept && (r_dcnt != 32'hFFFF_FFFF)) begin
      r_dcnt <= r_dcnt + 32'd1;
    end else begin
      r_dcnt <= r_dcnt;
    end
  end

  assign dummy_instr_cnt_o = r_dcnt;
`else
  assign dummy_instr_cnt_o = 32'h0;
`endif

endmodule
